// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: pin synchroniser, 16x baud tick generator, byte FIFO
// for the host, and sticky overrun / idle-line timeout flags.
module uart_rx_ctrl #(
  parameter int DVSR_W   = 11,
  parameter int FIFO_AW  = 2,
  parameter int TO_TICKS = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_pin,
  input  logic              en,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              s_tick,
  output logic              rx_sync,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_dout,
  input  logic              rd,
  output logic [7:0]        rd_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              overrun,
  output logic              timeout,
  input  logic              clr_err
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TO_W  = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

  logic              sync1, sync2;
  logic [DVSR_W-1:0] baud_cnt;
  logic [FIFO_AW:0]  wptr, rptr;
  logic [7:0]        mem [DEPTH];
  logic [TO_W-1:0]   to_cnt;
  logic              wr_req, wr_acc, rd_acc, drop, to_zero, to_hit;

  // Two-flop synchroniser; disabled receive presents an idle (high) line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
    end
  end

  assign rx_sync = en ? sync2 : 1'b1;

  // >= compare lets a shrinking divisor wrap at once instead of running to 2**DVSR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      s_tick   <= 1'b0;
    end else if (!en) begin
      baud_cnt <= '0;
      s_tick   <= 1'b0;
    end else if (baud_cnt >= dvsr) begin
      baud_cnt <= '0;
      s_tick   <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + DVSR_W'(1);
      s_tick   <= 1'b0;
    end
  end

  // Push: rx_done_tick (qualified by en) is a one-cycle strobe with no back-pressure;
  // a push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
  // Pop: rd is honoured only when the FIFO is non-empty; rd_data is the head (FWFT).
  assign rx_empty = (wptr == rptr);
  assign rx_full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                    (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign wr_req   = rx_done_tick & en;
  assign rd_acc   = rd & ~rx_empty;
  assign wr_acc   = wr_req & (~rx_full | rd_acc);
  assign drop     = wr_req & rx_full & ~rd_acc;
  assign rd_data  = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[FIFO_AW-1:0]] <= rx_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + (FIFO_AW+1)'(1);
      if (rd_acc) rptr <= rptr + (FIFO_AW+1)'(1);
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  // Idle timer only runs while data sits unread and the line stays high.
  assign to_zero = wr_acc | rd_acc | ~rx_sync | rx_empty;
  assign to_hit  = ~to_zero & s_tick & (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (to_zero)
        to_cnt <= '0;
      else if (s_tick && to_cnt != TO_LAST)
        to_cnt <= to_cnt + TO_W'(1);
      if (rd_acc || rx_empty) timeout <= 1'b0;
      else if (to_hit)        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud tick, synchroniser, FIFO, overrun,
// idle timeout and asynchronous reset, with hand-computed expectations.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_pin;
  logic        en;
  logic [10:0] dvsr;
  logic        s_tick;
  logic        rx_sync;
  logic        rx_done_tick;
  logic [7:0]  rx_dout;
  logic        rd;
  logic [7:0]  rd_data;
  logic        rx_empty;
  logic        rx_full;
  logic        overrun;
  logic        timeout;
  logic        clr_err;

  int tests_run = 0;
  int tests_failed = 0;

  uart_rx_ctrl #(.DVSR_W(11), .FIFO_AW(2), .TO_TICKS(640)) dut (
    .clk(clk), .reset(reset), .rx_pin(rx_pin), .en(en), .dvsr(dvsr),
    .s_tick(s_tick), .rx_sync(rx_sync), .rx_done_tick(rx_done_tick),
    .rx_dout(rx_dout), .rd(rd), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .overrun(overrun), .timeout(timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic pop);
    rx_done_tick = 1'b1;
    rx_dout      = b;
    rd           = pop;
    step();
    rx_done_tick = 1'b0;
    rd           = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, rd_data}, {24'h0, exp});
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_pin = 1'b1; en = 1'b0; dvsr = 11'd0;
    rx_done_tick = 1'b0; rx_dout = 8'h00; rd = 1'b0; clr_err = 1'b0;
    #1;
    check("rst_empty",   rx_empty, 1);
    check("rst_full",    rx_full,  0);
    check("rst_s_tick",  s_tick,   0);
    check("rst_rx_sync", rx_sync,  1);
    check("rst_overrun", overrun,  0);
    check("rst_timeout", timeout,  0);
    #2 reset = 1'b0;
    step(2);

    // Baud tick at dvsr=10: first pulse 11 clk after enable, then every 11 clk.
    dvsr = 11'd10; en = 1'b1;
    step(10); check("baud_pre_first", s_tick, 0);
    step();   check("baud_first",     s_tick, 1);
    step();   check("baud_one_cycle", s_tick, 0);
    step(9);  check("baud_pre_second", s_tick, 0);
    step();   check("baud_second",    s_tick, 1);
    en = 1'b0;
    step();   check("baud_disabled",  s_tick, 0);
    step(3);  check("baud_disabled2", s_tick, 0);
    en = 1'b1;
    step(10); check("baud_restart_pre", s_tick, 0);
    step();   check("baud_restart",     s_tick, 1);
    dvsr = 11'd0;
    step();   check("baud_dvsr0_a", s_tick, 1);
    step();   check("baud_dvsr0_b", s_tick, 1);
    step();   check("baud_dvsr0_c", s_tick, 1);

    // Synchroniser latency and enable gating.
    rx_pin = 1'b0;
    step();   check("sync_lat1", rx_sync, 1);
    step();   check("sync_lat2", rx_sync, 0);
    rx_pin = 1'b1;
    step(2);  check("sync_back_high", rx_sync, 1);
    en = 1'b0; rx_pin = 1'b0;
    step(3);  check("sync_en_off", rx_sync, 1);
    push(8'hEE, 1'b0);
    check("push_en_off_ignored", rx_empty, 1);
    rx_pin = 1'b1;
    step(2);
    en = 1'b1;
    step();

    // FIFO order and first-word fall-through.
    push(8'hA5, 1'b0);
    check("fifo_nonempty", rx_empty, 0);
    check("fifo_fwft", {24'h0, rd_data}, 32'hA5);
    push(8'h3C, 1'b0);
    push(8'h7E, 1'b0);
    check("fifo_not_full3", rx_full, 0);
    pop_check("fifo_pop0", 8'hA5);
    pop_check("fifo_pop1", 8'h3C);
    pop_check("fifo_pop2", 8'h7E);
    check("fifo_empty_after", rx_empty, 1);
    rd = 1'b1; step(); rd = 1'b0;
    check("rd_empty_ignored", rx_empty, 1);
    push(8'h11, 1'b0);
    check("fifo_after_rd_empty", {24'h0, rd_data}, 32'h11);
    pop_check("fifo_pop_11", 8'h11);

    // Overrun.
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    check("ovr_full", rx_full, 1);
    check("ovr_none_yet", overrun, 0);
    push(8'h99, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_head_kept", {24'h0, rd_data}, 32'h01);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("ovr_clr", overrun, 0);
    push(8'h55, 1'b1);
    check("ovr_wr_rd_full_none", overrun, 0);
    check("ovr_wr_rd_still_full", rx_full, 1);
    check("ovr_wr_rd_head", {24'h0, rd_data}, 32'h02);
    clr_err = 1'b1;
    push(8'h66, 1'b0);
    clr_err = 1'b0;
    check("ovr_set_wins", overrun, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("ovr_clr_alone", overrun, 0);
    pop_check("ovr_drain0", 8'h02);
    pop_check("ovr_drain1", 8'h03);
    pop_check("ovr_drain2", 8'h04);
    pop_check("ovr_drain3", 8'h55);
    check("ovr_drained", rx_empty, 1);

    // Timeout with dvsr=0 (tick every cycle): 640 ticks after the push.
    push(8'hC3, 1'b0);
    step(639); check("to_before", timeout, 0);
    step();    check("to_fire",   timeout, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("to_not_clr_err", timeout, 1);
    pop_check("to_pop_data", 8'hC3);
    check("to_clr_pop", timeout, 0);

    // Line low pulse restarts the idle timer: fires 940 ticks after the push.
    push(8'h5A, 1'b0);
    step(297);
    rx_pin = 1'b0; step(); rx_pin = 1'b1;
    step(342); check("to_pulse_not640", timeout, 0);
    step(299); check("to_pulse_before", timeout, 0);
    step();    check("to_pulse_fire",   timeout, 1);
    pop_check("to_pulse_pop", 8'h5A);
    check("to_pulse_clr", timeout, 0);

    // Asynchronous reset with 3 bytes held, overrun set, line low and ticks running.
    push(8'h21, 1'b0); push(8'h22, 1'b0); push(8'h23, 1'b0); push(8'h24, 1'b0);
    push(8'h25, 1'b0);
    rd = 1'b1; step(); rd = 1'b0;
    rx_pin = 1'b0;
    step(2);
    check("pre_rst_overrun", overrun, 1);
    check("pre_rst_s_tick",  s_tick,  1);
    check("pre_rst_rx_sync", rx_sync, 0);
    check("pre_rst_empty",   rx_empty, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_empty",   rx_empty, 1);
    check("arst_full",    rx_full,  0);
    check("arst_overrun", overrun,  0);
    check("arst_timeout", timeout,  0);
    check("arst_s_tick",  s_tick,   0);
    check("arst_rx_sync", rx_sync,  1);
    rx_pin = 1'b1;
    step();
    reset = 1'b0;
    step(2);
    check("post_rst_empty", rx_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
